m68k_bus_initiator: RTL



---
 rtl/m68k_bus_initiator.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_initiator.sv
// m68k_bus_initiator: acquires a 68000-style asynchronous bus through BR/BG/BGACK
// arbitration and runs read/write cycles for a local requester. Up to BURST_MAX
// cycles can run back to back in one tenure. A cycle ends on DTACK, on BERR, or
// after TIMEOUT_CYCLES wait states.
module m68k_bus_initiator #(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         BURST_MAX      = 4,
  parameter logic [2:0] FC_VALUE       = 3'b101
) (
  input  logic        CLK8,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [22:0] ADDR,
  input  logic [15:0] WDATA,
  input  logic [1:0]  BE,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        BR,
  input  logic        BG,
  output logic        BGACK,
  input  logic        AS_IN,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [2:0]  FC,
  output logic [22:0] A,
  output logic [15:0] D_OUT,
  input  logic [15:0] D_IN,
  output logic        D_OE,
  output logic        BUS_OE,
  input  logic        DTACK,
  input  logic        BERR
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BCW = $clog2(BURST_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ADDR, S_STRB, S_WAIT, S_TERM, S_HOLD, S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  bg_sync_q, bg_sync_d, as_sync_q, as_sync_d;
  logic [1:0]  dtack_sync_q, dtack_sync_d, berr_sync_q, berr_sync_d;
  logic        bg_s, as_in_s, dtack_s, berr_s;
  logic [WCW-1:0] wait_q, wait_d;
  logic [BCW-1:0] burst_q, burst_d;
  // Latched request
  logic        we_q, we_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        errf_q, errf_d;
  // Registered bus / local outputs
  logic        br_q, br_d, bgack_q, bgack_d;
  logic        as_q, as_d, uds_q, uds_d, lds_q, lds_d, rw_q, rw_d;
  logic [2:0]  fc_q, fc_d;
  logic [22:0] a_q, a_d;
  logic [15:0] dout_q, dout_d, rdata_q, rdata_d;
  logic        doe_q, doe_d, bus_oe_q, bus_oe_d, ack_q, ack_d, err_q, err_d;
  logic        latch, launch, term;

  assign bg_s    = bg_sync_q[1];
  assign as_in_s = as_sync_q[1];
  assign dtack_s = dtack_sync_q[1];
  assign berr_s  = berr_sync_q[1];

  // Next-state and output computation; every register holds unless a state says otherwise
  always_comb begin
    state_d      = state_q;
    bg_sync_d    = {bg_sync_q[0], BG};
    as_sync_d    = {as_sync_q[0], AS_IN};
    dtack_sync_d = {dtack_sync_q[0], DTACK};
    berr_sync_d  = {berr_sync_q[0], BERR};
    wait_d  = wait_q;
    burst_d = burst_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    errf_d  = errf_q;
    br_d    = br_q;
    bgack_d = bgack_q;
    as_d    = as_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    rw_d    = rw_q;
    fc_d    = fc_q;
    a_d     = a_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    doe_d   = doe_q;
    bus_oe_d = bus_oe_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    latch   = 1'b0;
    launch  = 1'b0;
    term    = 1'b0;

    case (state_q)
      S_IDLE: if (REQ) begin
        latch   = 1'b1;
        br_d    = 1'b0;
        state_d = S_ARB;
      end
      // Take the bus only once the previous master has fully let go
      S_ARB: if (!bg_s && as_in_s && dtack_s) begin
        bgack_d = 1'b0;
        br_d    = 1'b1;
        burst_d = '0;
        launch  = 1'b1;
      end
      S_ADDR: begin
        as_d    = 1'b0;
        uds_d   = ~be_q[1];
        lds_d   = ~be_q[0];
        state_d = S_STRB;
      end
      S_STRB: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      // BERR has priority over DTACK; timeout only when neither responded
      S_WAIT: begin
        wait_d = wait_q + WCW'(1);
        if (!berr_s) begin
          errf_d = 1'b1;
          term   = 1'b1;
        end else if (!dtack_s) begin
          if (!we_q) rdata_d = D_IN;
          term = 1'b1;
        end else if (wait_q == WCW'(TIMEOUT_CYCLES - 1)) begin
          errf_d = 1'b1;
          term   = 1'b1;
        end
      end
      S_TERM: begin
        wait_d  = '0;
        burst_d = burst_q + BCW'(1);
        state_d = S_HOLD;
      end
      // Wait for the slave to negate its handshake before reusing or dropping the bus
      S_HOLD: if (dtack_s && berr_s) begin
        if (REQ && !errf_q && burst_q < BCW'(BURST_MAX)) begin
          latch  = 1'b1;
          launch = 1'b1;
        end else begin
          bus_oe_d = 1'b0;
          doe_d    = 1'b0;
          bgack_d  = 1'b1;
          rw_d     = 1'b1;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (latch) begin
      we_d    = WE;
      addr_d  = ADDR;
      wdata_d = WDATA;
      be_d    = (BE == 2'b00) ? 2'b11 : BE;
      errf_d  = 1'b0;
    end
    // Drive address phase from the (possibly just latched) request
    if (launch) begin
      bus_oe_d = 1'b1;
      fc_d     = FC_VALUE;
      a_d      = addr_d;
      rw_d     = ~we_d;
      doe_d    = we_d;
      dout_d   = wdata_d;
      state_d  = S_ADDR;
    end
    if (term) begin
      as_d    = 1'b1;
      uds_d   = 1'b1;
      lds_d   = 1'b1;
      ack_d   = 1'b1;
      err_d   = errf_d;
      state_d = S_TERM;
    end
  end

  // State and output registers with synchronous reset releasing the bus
  always_ff @(posedge CLK8) begin
    if (RST) begin
      state_q      <= S_IDLE;
      bg_sync_q    <= 2'b11;
      as_sync_q    <= 2'b11;
      dtack_sync_q <= 2'b11;
      berr_sync_q  <= 2'b11;
      wait_q   <= '0;
      burst_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 2'b11;
      errf_q   <= 1'b0;
      br_q     <= 1'b1;
      bgack_q  <= 1'b1;
      as_q     <= 1'b1;
      uds_q    <= 1'b1;
      lds_q    <= 1'b1;
      rw_q     <= 1'b1;
      fc_q     <= '0;
      a_q      <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      doe_q    <= 1'b0;
      bus_oe_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bg_sync_q    <= bg_sync_d;
      as_sync_q    <= as_sync_d;
      dtack_sync_q <= dtack_sync_d;
      berr_sync_q  <= berr_sync_d;
      wait_q   <= wait_d;
      burst_q  <= burst_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      errf_q   <= errf_d;
      br_q     <= br_d;
      bgack_q  <= bgack_d;
      as_q     <= as_d;
      uds_q    <= uds_d;
      lds_q    <= lds_d;
      rw_q     <= rw_d;
      fc_q     <= fc_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      doe_q    <= doe_d;
      bus_oe_q <= bus_oe_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign ACK    = ack_q;
  assign ERR    = err_q;
  assign RDATA  = rdata_q;
  assign BUSY   = (state_q != S_IDLE);
  assign BR     = br_q;
  assign BGACK  = bgack_q;
  assign AS     = as_q;
  assign UDS    = uds_q;
  assign LDS    = lds_q;
  assign RW     = rw_q;
  assign FC     = fc_q;
  assign A      = a_q;
  assign D_OUT  = dout_q;
  assign D_OE   = doe_q;
  assign BUS_OE = bus_oe_q;

endmodule
